// File: rtl/wb_master_engine_if.sv
// ============================================================================
// Module : wb_master_engine_if
// Brief  : Command/write-data/response streams plus Wishbone bus bundle
//          connecting the burst master engine to its user and its slave.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface wb_master_engine_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int ADDR_LSB   = 2,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = DATA_WIDTH / 8,
    parameter int LEN_WIDTH  = 4
);
    logic                         cmd_valid_i;
    logic                         cmd_ready_o;
    logic                         cmd_we_i;
    logic [ADDR_WIDTH-1:0]        cmd_adr_i;
    logic [SEL_WIDTH-1:0]         cmd_sel_i;
    logic [LEN_WIDTH-1:0]         cmd_len_i;
    logic                         wdat_valid_i;
    logic                         wdat_ready_o;
    logic [DATA_WIDTH-1:0]        wdat_i;
    logic                         rsp_valid_o;
    logic                         rsp_ready_i;
    logic [DATA_WIDTH-1:0]        rsp_dat_o;
    logic                         rsp_err_o;
    logic                         rsp_last_o;
    logic                         timeout_o;
    logic                         busy_o;
    logic [ADDR_WIDTH-ADDR_LSB-1:0] wb_adr_o;
    logic [DATA_WIDTH-1:0]        wb_dat_o;
    logic [SEL_WIDTH-1:0]         wb_sel_o;
    logic                         wb_we_o;
    logic                         wb_cyc_o;
    logic                         wb_stb_o;
    logic [DATA_WIDTH-1:0]        wb_dat_i;
    logic                         wb_ack_i;
    logic                         wb_err_i;

    // Engine side
    modport master (
        input  cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_len_i,
        output cmd_ready_o,
        input  wdat_valid_i, wdat_i,
        output wdat_ready_o,
        output rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o,
        input  rsp_ready_i,
        output timeout_o, busy_o,
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        input  wb_dat_i, wb_ack_i, wb_err_i
    );

    // User/slave side
    modport slave (
        output cmd_valid_i, cmd_we_i, cmd_adr_i, cmd_sel_i, cmd_len_i,
        input  cmd_ready_o,
        output wdat_valid_i, wdat_i,
        input  wdat_ready_o,
        input  rsp_valid_o, rsp_dat_o, rsp_err_o, rsp_last_o,
        output rsp_ready_i,
        input  timeout_o, busy_o,
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o,
        output wb_dat_i, wb_ack_i, wb_err_i
    );
endinterface

`default_nettype wire

// File: rtl/wb_master_engine.sv
// ============================================================================
// Module : wb_master_engine
// Brief  : Wishbone classic-cycle burst master: command in, incrementing
//          beats under one CYC, one response per beat, ERR/timeout abort.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module wb_master_engine #(
    parameter int ADDR_WIDTH     = 32,
    parameter int ADDR_LSB       = 2,
    parameter int DATA_WIDTH     = 32,
    parameter int SEL_WIDTH      = DATA_WIDTH / 8,
    parameter int MAX_BURST      = 16,
    parameter int LEN_WIDTH      = $clog2(MAX_BURST),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_n_i,
    wb_master_engine_if.master   bus
);
    localparam int WA = ADDR_WIDTH - ADDR_LSB;
    localparam int TW = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] C_TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WDATA  = 2'd1,
        S_STROBE = 2'd2,
        S_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [LEN_WIDTH-1:0]  r_beat;
    logic [LEN_WIDTH-1:0]  r_len;
    logic [TW-1:0]         r_tcnt;
    logic [WA-1:0]         r_adr;
    logic [DATA_WIDTH-1:0] r_dat;
    logic [SEL_WIDTH-1:0]  r_sel;
    logic                  r_we;
    logic                  r_cyc;
    logic                  r_stb;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_dat;
    logic                  r_rsp_err;
    logic                  r_rsp_last;
    logic                  r_timeout;
    logic                  r_busy;

    logic w_last;
    logic w_tmo;
    logic w_done;
    logic w_fail;

    assign w_last = (r_beat == r_len);
    assign w_tmo  = (r_tcnt == C_TMO_LAST);
    assign w_done = bus.wb_ack_i | bus.wb_err_i | w_tmo;
    // A timeout counts as an error only when the slave did not answer on that edge
    assign w_fail = bus.wb_err_i | (w_tmo & ~bus.wb_ack_i);

    generate
        if (ADDR_LSB > 0) begin : g_adr_lsb
            logic w_unused_adr_lsb;
            assign w_unused_adr_lsb = ^bus.cmd_adr_i[ADDR_LSB-1:0];
        end
    endgenerate

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state     <= S_IDLE;
            r_beat      <= '0;
            r_len       <= '0;
            r_tcnt      <= '0;
            r_adr       <= '0;
            r_dat       <= '0;
            r_sel       <= '0;
            r_we        <= 1'b0;
            r_cyc       <= 1'b0;
            r_stb       <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_dat   <= '0;
            r_rsp_err   <= 1'b0;
            r_rsp_last  <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.cmd_valid_i) begin
                        r_adr  <= bus.cmd_adr_i[ADDR_WIDTH-1:ADDR_LSB];
                        r_sel  <= bus.cmd_sel_i;
                        r_we   <= bus.cmd_we_i;
                        r_len  <= bus.cmd_len_i;
                        r_beat <= '0;
                        r_tcnt <= '0;
                        r_cyc  <= 1'b1;
                        r_busy <= 1'b1;
                        if (bus.cmd_we_i) begin
                            r_state <= S_WDATA;
                        end else begin
                            r_stb   <= 1'b1;
                            r_state <= S_STROBE;
                        end
                    end
                end
                S_WDATA: begin
                    if (bus.wdat_valid_i) begin
                        r_dat   <= bus.wdat_i;
                        r_stb   <= 1'b1;
                        r_tcnt  <= '0;
                        r_state <= S_STROBE;
                    end
                end
                S_STROBE: begin
                    if (w_done) begin
                        r_stb       <= 1'b0;
                        r_cyc       <= ~(w_last | w_fail);
                        r_rsp_valid <= 1'b1;
                        r_rsp_err   <= w_fail;
                        r_rsp_last  <= w_last | w_fail;
                        r_rsp_dat   <= (r_we || !(bus.wb_ack_i || bus.wb_err_i)) ? '0 : bus.wb_dat_i;
                        r_timeout   <= ~(bus.wb_ack_i | bus.wb_err_i);
                        r_tcnt      <= '0;
                        r_state     <= S_RESP;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
                end
                S_RESP: begin
                    if (bus.rsp_ready_i) begin
                        r_rsp_valid <= 1'b0;
                        if (r_rsp_last) begin
                            r_busy  <= 1'b0;
                            r_state <= S_IDLE;
                        end else begin
                            r_adr  <= r_adr + 1'b1;
                            r_beat <= r_beat + 1'b1;
                            if (r_we) begin
                                r_state <= S_WDATA;
                            end else begin
                                r_stb   <= 1'b1;
                                r_tcnt  <= '0;
                                r_state <= S_STROBE;
                            end
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready_o  = (r_state == S_IDLE);
    assign bus.wdat_ready_o = (r_state == S_WDATA);
    assign bus.rsp_valid_o  = r_rsp_valid;
    assign bus.rsp_dat_o    = r_rsp_dat;
    assign bus.rsp_err_o    = r_rsp_err;
    assign bus.rsp_last_o   = r_rsp_last;
    assign bus.timeout_o    = r_timeout;
    assign bus.busy_o       = r_busy;
    assign bus.wb_adr_o     = r_adr;
    assign bus.wb_dat_o     = r_dat;
    assign bus.wb_sel_o     = r_sel;
    assign bus.wb_we_o      = r_we;
    assign bus.wb_cyc_o     = r_cyc;
    assign bus.wb_stb_o     = r_stb;

endmodule

`default_nettype wire

// File: tb/tb_wb_master_engine.sv
// ============================================================================
// Module : tb_wb_master_engine
// Brief  : Directed self-checking bench for the Wishbone burst master engine.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_wb_master_engine;
    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    int   n;

    wb_master_engine_if #(
        .ADDR_WIDTH(32), .ADDR_LSB(2), .DATA_WIDTH(32), .SEL_WIDTH(4), .LEN_WIDTH(4)
    ) bus ();

    wb_master_engine #(
        .ADDR_WIDTH(32), .ADDR_LSB(2), .DATA_WIDTH(32), .SEL_WIDTH(4),
        .MAX_BURST(16), .LEN_WIDTH(4), .TIMEOUT_CYCLES(256)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_n_i (rst_n),
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic send_cmd(input logic we, input logic [31:0] adr,
                            input logic [3:0] sel, input logic [3:0] len);
        bus.cmd_valid_i = 1'b1;
        bus.cmd_we_i    = we;
        bus.cmd_adr_i   = adr;
        bus.cmd_sel_i   = sel;
        bus.cmd_len_i   = len;
        step();
        bus.cmd_valid_i = 1'b0;
    endtask

    task automatic slave_ack(input logic [31:0] dat, input logic err);
        bus.wb_ack_i = 1'b1;
        bus.wb_err_i = err;
        bus.wb_dat_i = dat;
        step();
        bus.wb_ack_i = 1'b0;
        bus.wb_err_i = 1'b0;
        bus.wb_dat_i = '0;
    endtask

    task automatic rsp_take();
        bus.rsp_ready_i = 1'b1;
        step();
        bus.rsp_ready_i = 1'b0;
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b0;
        bus.cmd_valid_i = 1'b0; bus.cmd_we_i = 1'b0; bus.cmd_adr_i = '0;
        bus.cmd_sel_i = '0; bus.cmd_len_i = '0;
        bus.wdat_valid_i = 1'b0; bus.wdat_i = '0; bus.rsp_ready_i = 1'b0;
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0;

        // Reset state
        step(); step();
        chk("rst_cmd_ready", bus.cmd_ready_o, 1);
        chk("rst_cyc", bus.wb_cyc_o, 0);
        chk("rst_stb", bus.wb_stb_o, 0);
        chk("rst_busy", bus.busy_o, 0);
        chk("rst_rsp_valid", bus.rsp_valid_o, 0);
        rst_n = 1'b1;
        step();

        // Single read 0x48, ACK after 2 cycles
        send_cmd(1'b0, 32'h48, 4'hF, 4'd0);
        chk("rd1_stb", bus.wb_stb_o, 1);
        chk("rd1_cyc", bus.wb_cyc_o, 1);
        chk("rd1_adr", bus.wb_adr_o, 30'h12);
        chk("rd1_we", bus.wb_we_o, 0);
        chk("rd1_busy", bus.busy_o, 1);
        chk("rd1_cmd_ready", bus.cmd_ready_o, 0);
        step();
        chk("rd1_stb_wait", bus.wb_stb_o, 1);
        slave_ack(32'hDEADBEEF, 1'b0);
        chk("rd1_rsp_valid", bus.rsp_valid_o, 1);
        chk("rd1_rsp_dat", bus.rsp_dat_o, 32'hDEADBEEF);
        chk("rd1_rsp_last", bus.rsp_last_o, 1);
        chk("rd1_rsp_err", bus.rsp_err_o, 0);
        chk("rd1_cyc_low", bus.wb_cyc_o, 0);
        chk("rd1_stb_low", bus.wb_stb_o, 0);
        step();
        chk("rd1_rsp_hold", bus.rsp_valid_o, 1);
        rsp_take();
        chk("rd1_rsp_done", bus.rsp_valid_o, 0);
        chk("rd1_idle_ready", bus.cmd_ready_o, 1);
        chk("rd1_idle_busy", bus.busy_o, 0);

        // Single write 0x04
        send_cmd(1'b1, 32'h04, 4'h3, 4'd0);
        chk("wr1_cyc", bus.wb_cyc_o, 1);
        chk("wr1_stb_low", bus.wb_stb_o, 0);
        chk("wr1_wdat_ready", bus.wdat_ready_o, 1);
        bus.wdat_valid_i = 1'b1; bus.wdat_i = 32'h0000A5A5;
        step();
        bus.wdat_valid_i = 1'b0;
        chk("wr1_stb", bus.wb_stb_o, 1);
        chk("wr1_adr", bus.wb_adr_o, 30'h1);
        chk("wr1_sel", bus.wb_sel_o, 4'h3);
        chk("wr1_we", bus.wb_we_o, 1);
        chk("wr1_dat", bus.wb_dat_o, 32'h0000A5A5);
        slave_ack(32'h12345678, 1'b0);
        chk("wr1_rsp_valid", bus.rsp_valid_o, 1);
        chk("wr1_rsp_last", bus.rsp_last_o, 1);
        chk("wr1_rsp_dat", bus.rsp_dat_o, 0);
        rsp_take();

        // Burst write len=3 from 0x100 with 2-cycle data gaps
        send_cmd(1'b1, 32'h100, 4'hF, 4'd3);
        for (int i = 0; i < 4; i++) begin
            step(); step();
            chk("bw_gap_cyc", bus.wb_cyc_o, 1);
            chk("bw_gap_stb", bus.wb_stb_o, 0);
            bus.wdat_valid_i = 1'b1; bus.wdat_i = 32'h1000 + i;
            step();
            bus.wdat_valid_i = 1'b0;
            chk("bw_stb", bus.wb_stb_o, 1);
            chk("bw_adr", bus.wb_adr_o, 30'h40 + i);
            chk("bw_dat", bus.wb_dat_o, 32'h1000 + i);
            slave_ack(32'h0, 1'b0);
            chk("bw_last", bus.rsp_last_o, (i == 3));
            chk("bw_cyc", bus.wb_cyc_o, (i != 3));
            rsp_take();
        end
        chk("bw_idle", bus.cmd_ready_o, 1);

        // Burst read len=3 with 3 cycles of response back-pressure per beat
        send_cmd(1'b0, 32'h200, 4'hF, 4'd3);
        for (int i = 0; i < 4; i++) begin
            chk("br_stb", bus.wb_stb_o, 1);
            chk("br_adr", bus.wb_adr_o, 30'h80 + i);
            slave_ack(32'hC0DE0000 + i, 1'b0);
            chk("br_dat", bus.rsp_dat_o, 32'hC0DE0000 + i);
            chk("br_last", bus.rsp_last_o, (i == 3));
            for (int k = 0; k < 3; k++) begin
                step();
                chk("br_no_stb", bus.wb_stb_o, 0);
                chk("br_rsp_hold", bus.rsp_valid_o, 1);
            end
            rsp_take();
        end
        chk("br_idle", bus.cmd_ready_o, 1);

        // Read len=3, ERR together with ACK on the second beat
        send_cmd(1'b0, 32'h0, 4'hF, 4'd3);
        slave_ack(32'h11111111, 1'b0);
        chk("er_b0_err", bus.rsp_err_o, 0);
        rsp_take();
        chk("er_b1_stb", bus.wb_stb_o, 1);
        slave_ack(32'h22222222, 1'b1);
        chk("er_rsp_err", bus.rsp_err_o, 1);
        chk("er_rsp_last", bus.rsp_last_o, 1);
        chk("er_cyc", bus.wb_cyc_o, 0);
        chk("er_timeout", bus.timeout_o, 0);
        rsp_take();
        chk("er_cmd_ready", bus.cmd_ready_o, 1);

        // Timeout: no ACK for 256 cycles
        send_cmd(1'b0, 32'h10, 4'hF, 4'd0);
        chk("to_stb", bus.wb_stb_o, 1);
        n = 0;
        while (bus.timeout_o !== 1'b1 && n < 300) begin
            step();
            n++;
        end
        chk("to_cycles", n, 256);
        chk("to_rsp_err", bus.rsp_err_o, 1);
        chk("to_rsp_last", bus.rsp_last_o, 1);
        chk("to_cyc", bus.wb_cyc_o, 0);
        step();
        chk("to_pulse", bus.timeout_o, 0);
        rsp_take();

        // Word address wrap from the top of the address space
        send_cmd(1'b0, 32'hFFFF_FFFC, 4'hF, 4'd1);
        chk("wrap_adr0", bus.wb_adr_o, 30'h3FFF_FFFF);
        slave_ack(32'hAAAA5555, 1'b0);
        rsp_take();
        chk("wrap_adr1", bus.wb_adr_o, 30'h0);
        chk("wrap_stb1", bus.wb_stb_o, 1);
        slave_ack(32'h5555AAAA, 1'b0);
        chk("wrap_last", bus.rsp_last_o, 1);
        rsp_take();

        // Asynchronous reset mid-burst with a response pending
        send_cmd(1'b0, 32'h300, 4'hF, 4'd3);
        slave_ack(32'h33333333, 1'b0);
        chk("ar_pre_cyc", bus.wb_cyc_o, 1);
        chk("ar_pre_rsp", bus.rsp_valid_o, 1);
        rst_n = 1'b0;
        #1;
        chk("ar_cyc", bus.wb_cyc_o, 0);
        chk("ar_stb", bus.wb_stb_o, 0);
        chk("ar_rsp_valid", bus.rsp_valid_o, 0);
        chk("ar_cmd_ready", bus.cmd_ready_o, 1);
        chk("ar_busy", bus.busy_o, 0);
        step();
        rst_n = 1'b1;
        step();

        // Recovery after reset
        send_cmd(1'b0, 32'h8, 4'hF, 4'd0);
        chk("rec_adr", bus.wb_adr_o, 30'h2);
        slave_ack(32'h0BADF00D, 1'b0);
        chk("rec_dat", bus.rsp_dat_o, 32'h0BADF00D);
        rsp_take();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

`default_nettype wire

// File: doc/wb_master_engine.md
Name: wb_master_engine

Overview:
Synthesizable, parametrised Wishbone classic-cycle master that replaces task-driven single-beat access with a command/response stream engine. Accepts burst read/write commands, sequences incrementing-address beats under one held CYC, and returns per-beat responses. Adds byte-select control, back-pressure, early error termination and a bus timeout. Sits between testbench/emulation transactors or on-chip control logic and the ethmac slave register/buffer-descriptor port.

Parameters:
ADDR_WIDTH, 32, byte address width of cmd_adr
ADDR_LSB, 2, low byte-address bits dropped when driving wb_adr_o
DATA_WIDTH, 32, data bus width, multiple of 8
SEL_WIDTH, DATA_WIDTH/8, byte-select width
MAX_BURST, 16, maximum beats per command, power of 2
LEN_WIDTH, $clog2(MAX_BURST), width of cmd_len
TIMEOUT_CYCLES, 256, cycles STB may wait for ACK/ERR, >= 2

Ports:
wb_clk_i  in  1  clock
wb_rst_n_i  in  1  asynchronous active-low reset
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command ready
cmd_we_i  in  1  1 = write, 0 = read
cmd_adr_i  in  ADDR_WIDTH  start byte address
cmd_sel_i  in  SEL_WIDTH  byte selects for every beat
cmd_len_i  in  LEN_WIDTH  beats minus one
wdat_valid_i  in  1  write data valid
wdat_ready_o  out  1  write data ready
wdat_i  in  DATA_WIDTH  write data
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response ready
rsp_dat_o  out  DATA_WIDTH  read data (0 for writes)
rsp_err_o  out  1  beat ended by ERR or timeout
rsp_last_o  out  1  final response of command
timeout_o  out  1  one-cycle pulse on timeout
busy_o  out  1  command in progress
wb_adr_o  out  ADDR_WIDTH-ADDR_LSB  word address
wb_dat_o  out  DATA_WIDTH  write data
wb_sel_o  out  SEL_WIDTH  byte selects
wb_we_o  out  1  write enable
wb_cyc_o  out  1  cycle
wb_stb_o  out  1  strobe
wb_dat_i  in  DATA_WIDTH  read data from slave
wb_ack_i  in  1  acknowledge
wb_err_i  in  1  error

Behaviour:
- Reset (async, any state): all outputs 0 except cmd_ready_o; FSM -> IDLE; counters cleared. cmd_ready_o = 1 in IDLE only.
- States: IDLE, WDATA, STROBE, RESP.
- IDLE: on cmd_valid_i & cmd_ready_o latch we/adr/sel/len, beat count = 0; next cycle cyc=1, busy=1, wb_adr_o = cmd_adr_i[ADDR_WIDTH-1:ADDR_LSB], sel, we driven; -> WDATA if write, else STROBE with stb=1.
- WDATA: wdat_ready_o = 1 (combinational on state). On handshake, register wdat_i to wb_dat_o, stb=1 next cycle -> STROBE. wdat gaps stall with cyc=1, stb=0.
- STROBE: stb held; sampled at posedge: ERR has priority over simultaneous ACK. On ACK/ERR: stb=0 next cycle; capture wb_dat_i (reads) into rsp_dat_o; rsp_valid=1, rsp_err=ERR, rsp_last = (final beat | ERR); -> RESP. Timeout counter runs while stb=1; at TIMEOUT_CYCLES without ACK/ERR, treated as ERR plus timeout_o pulse.
- Last beat or error: cyc drops together with stb.
- RESP: hold response until rsp_ready_i. On handshake: if last -> IDLE (cmd_ready next cycle, busy=0); else adr += 1 (wraps modulo 2^(ADDR_WIDTH-ADDR_LSB)), -> WDATA (write) or STROBE with stb=1 next cycle (read).
- No STB while response pending; responses never dropped. Timeout counter clears per beat.
- Minimum single-read latency: accept -> STB 1 cycle; ACK -> rsp_valid 1 cycle.
- wb_dat_o/wb_adr_o/wb_sel_o stable while stb=1.

Test Plan:
- Single read, adr 0x48, sel 0xF, slave ACK after 2 cycles with 0xDEADBEEF -> wb_adr_o 0x12, one rsp: dat 0xDEADBEEF, last=1, err=0; cyc low after ACK.
- Single write adr 0x04, sel 0x3, data 0x0000A5A5 -> wb_sel_o 0x3, wb_we_o 1, wb_dat_o 0x0000A5A5; rsp last=1, dat 0.
- Burst write len=3 from 0x100, 2-cycle wdat gaps -> 4 beats at word adr 0x40..0x43, cyc continuous, stb low during gaps.
- Burst read len=3 with rsp_ready low 3 cycles per beat -> no STB while rsp pending, 4 ordered responses, last on 4th only.
- Read len=3, ERR (with ACK) on beat 2 -> 2 responses, second err=1 last=1, cyc drops, cmd_ready 1 next cycle; separately no ACK for 256 cycles -> timeout_o pulse, rsp err=1 last=1.
- Burst from word adr 0x3FF...F (max) -> wraps to 0; assert wb_rst_n_i mid-burst -> cyc/stb/rsp_valid 0 immediately, cmd_ready 1.
